// File: rtl/adpcm_ima_decoder.sv
// adpcm_ima_decoder
//   IMA ADPCM decoder. Takes packed 4-bit codes, two per byte with the low
//   nibble first, and rebuilds 16-bit signed PCM samples. Its predictor and
//   step-index arithmetic are kept bit-identical to the encoder's predictor,
//   so a loopback through this block reproduces the encoder's prediction.
//
// Optional build macro: ADPCM_DEC_HDR_EN
//   When defined, the in_hdr port exists. A header byte in IDLE starts a
//   4-byte header that loads pred[7:0], pred[15:8], the step index, and one
//   reserved byte. The header produces no output sample.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous, active-high reset
//   in_byte        in   [7:0] packed codes, [3:0] decoded first
//   in_byte_vld    in   in_byte valid
//   in_byte_rdy    out  decoder accepts in_byte this cycle
//   out_sample     out  [PRED_W-1:0] reconstructed signed sample (registered)
//   out_sample_vld out  out_sample valid
//   out_sample_rdy in   consumer accepts out_sample
//   in_hdr         in   (ADPCM_DEC_HDR_EN only) in_byte is a header byte
module adpcm_ima_decoder #(
  parameter int STEP_MAX_IDX = 88,
  parameter int PRED_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_byte,
  input  logic                     in_byte_vld,
  output logic                     in_byte_rdy,
  output logic signed [PRED_W-1:0] out_sample,
  output logic                     out_sample_vld,
  input  logic                     out_sample_rdy
`ifdef ADPCM_DEC_HDR_EN
  ,
  input  logic                     in_hdr
`endif
);

  if (PRED_W != 16) begin : g_pred_w_check
    $error("adpcm_ima_decoder: PRED_W must be 16");
  end

  localparam logic [6:0] MAX_IDX7 = 7'(STEP_MAX_IDX);
  localparam logic [7:0] MAX_IDX8 = 8'(STEP_MAX_IDX);

  localparam logic [14:0] STEP_TABLE [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,
    15'd14,    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,
    15'd28,    15'd31,    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,
    15'd55,    15'd60,    15'd66,    15'd73,    15'd80,    15'd88,    15'd97,
    15'd107,   15'd118,   15'd130,   15'd143,   15'd157,   15'd173,   15'd190,
    15'd209,   15'd230,   15'd253,   15'd279,   15'd307,   15'd337,   15'd371,
    15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,   15'd724,
    15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,
    15'd3024,  15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,
    15'd5894,  15'd6484,  15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442,
    15'd11487, 15'd12635, 15'd13899, 15'd15289, 15'd16818, 15'd18500, 15'd20350,
    15'd22385, 15'd24623, 15'd27086, 15'd29794, 15'd32767
  };

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_H0   = 3'd3,
    S_H1   = 3'd4,
    S_H2   = 3'd5
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] p);
    if (p > 18'sd32767)       return 16'sh7fff;
    else if (p < -18'sd32768) return 16'sh8000;
    else                      return p[15:0];
  endfunction

  function automatic logic [6:0] next_index(input logic [6:0] idx, input logic [2:0] c);
    logic signed [8:0] d;
    logic signed [8:0] t;
    case (c)
      3'd4:    d = 9'sd2;
      3'd5:    d = 9'sd4;
      3'd6:    d = 9'sd6;
      3'd7:    d = 9'sd8;
      default: d = -9'sd1;
    endcase
    t = $signed({2'b00, idx}) + d;
    if (t < 9'sd0)                         return 7'd0;
    else if (t > $signed({2'b00, MAX_IDX7})) return MAX_IDX7;
    else                                   return t[6:0];
  endfunction

  state_t             r_state;
  logic [7:0]         r_byte;
  logic signed [15:0] r_pred;
  logic [6:0]         r_index;
  logic signed [15:0] r_out;
  logic               r_out_vld;

  logic               w_out_ld;
  logic               w_load;
  logic [3:0]         w_nib;
  logic [14:0]        w_step;
  logic [16:0]        w_diff;
  logic signed [17:0] w_p;
  logic signed [15:0] w_new_pred;
  logic [6:0]         w_new_index;

  // Decode stage: one nibble of the latched byte, combinational from r_pred/r_index
  always_comb begin
    w_out_ld = ~r_out_vld | out_sample_rdy;
    w_load   = w_out_ld & ((r_state == S_LO) | (r_state == S_HI));
    w_nib    = (r_state == S_HI) ? r_byte[7:4] : r_byte[3:0];
    w_step   = STEP_TABLE[r_index];
    w_diff   = 17'(w_step >> 3);
    if (w_nib[2]) w_diff = w_diff + 17'(w_step);
    if (w_nib[1]) w_diff = w_diff + 17'(w_step >> 1);
    if (w_nib[0]) w_diff = w_diff + 17'(w_step >> 2);
    if (w_nib[3]) w_p = $signed({{2{r_pred[15]}}, r_pred}) - $signed({1'b0, w_diff});
    else          w_p = $signed({{2{r_pred[15]}}, r_pred}) + $signed({1'b0, w_diff});
    w_new_pred  = sat16(w_p);
    w_new_index = next_index(r_index, w_nib[2:0]);

    case (r_state)
      S_IDLE:  in_byte_rdy = 1'b1;
      S_HI:    in_byte_rdy = w_out_ld;
      S_H0,
      S_H1,
      S_H2:    in_byte_rdy = 1'b1;
      default: in_byte_rdy = 1'b0;
    endcase
  end

  // Output register stage: FSM, predictor state and registered sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pred    <= '0;
      r_index   <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_load)              r_out_vld <= 1'b1;
      else if (out_sample_rdy) r_out_vld <= 1'b0;

      if (w_load) begin
        r_out   <= w_new_pred;
        r_pred  <= w_new_pred;
        r_index <= w_new_index;
      end

      case (r_state)
        S_IDLE: begin
          if (in_byte_vld) begin
`ifdef ADPCM_DEC_HDR_EN
            if (in_hdr) begin
              r_pred[7:0] <= in_byte;
              r_state     <= S_H0;
            end else begin
              r_byte  <= in_byte;
              r_state <= S_LO;
            end
`else
            r_byte  <= in_byte;
            r_state <= S_LO;
`endif
          end
        end
        S_LO: begin
          if (w_out_ld) r_state <= S_HI;
        end
        S_HI: begin
          if (w_out_ld) begin
            if (in_byte_vld) begin
              r_byte  <= in_byte;
              r_state <= S_LO;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
`ifdef ADPCM_DEC_HDR_EN
        S_H0: begin
          if (in_byte_vld) begin
            r_pred[15:8] <= in_byte;
            r_state      <= S_H1;
          end
        end
        S_H1: begin
          if (in_byte_vld) begin
            r_index <= (in_byte > MAX_IDX8) ? MAX_IDX7 : in_byte[6:0];
            r_state <= S_H2;
          end
        end
        S_H2: begin
          if (in_byte_vld) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_sample     = r_out;
  assign out_sample_vld = r_out_vld;

endmodule
